// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry frame receiver.
// Holds the default sync byte, field widths, the parser state encoding
// and the packed coordinate record written to the coordinate store.
package telem_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         SLOT_W       = 5;
  localparam int         COORD_W      = 8;

  // One state per byte position in the frame; HUNT waits for the sync byte.
  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    X,
    Y,
    Z,
    T,
    CHK
  } state_t;

  // Field order matches the store word: x lands in [31:24].
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] t;
  } coord_t;

endpackage

// File: rtl/telem_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an inc pulse one cycle after it is asserted.
// Backpressure: none; every inc pulse is taken.
// Ports: clk/rst (sync, active-high), inc (count one event), cnt (current value).
module telem_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/telem_frame_rx.sv
// Telemetry frame receiver: sync hunt, parse slot + X/Y/Z/T + XOR checksum, emit one store write per good frame.
// Latency: write and counter update visible one cycle after the checksum byte is accepted.
// Backpressure: in_ready drops only while a checksum byte waits on an unaccepted pending write.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready byte stream in;
//        wr_valid/wr_ready/wr_slot/wr_data store write out; ok_cnt/err_cnt frame counters; busy = mid-frame.
module telem_frame_rx
  import telem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [4:0]  wr_slot,
  output logic [31:0] wr_data,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt,
  output logic        busy
);

  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t              state;
  logic [SLOT_W-1:0]   slot_q;
  coord_t              coord_q;
  logic [7:0]          chk_q;
  logic [IDLE_W-1:0]   idle_cnt;

  logic accept;
  logic addr_bad;
  logic chk_good;
  logic chk_bad;
  logic timeout_hit;

  // A checksum byte may only land once the output register is free or
  // draining this cycle, so the stall is confined to the CHK state.
  assign in_ready = !((state == CHK) && wr_valid && !wr_ready);
  assign accept   = in_valid && in_ready;

  assign addr_bad = accept && (state == ADDR) && (in_data[7:5] != 3'd0);
  assign chk_good = accept && (state == CHK) && (in_data == chk_q);
  assign chk_bad  = accept && (state == CHK) && (in_data != chk_q);

  // Fires on the idle edge that would bring the count to TIMEOUT; a stalled
  // CHK (in_ready low) never counts as idle.
  assign timeout_hit = (TIMEOUT != 0) && (state != HUNT) && !accept && in_ready &&
                       ((32'(idle_cnt) + 32'd1) == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      slot_q   <= '0;
      coord_q  <= '0;
      chk_q    <= 8'd0;
      idle_cnt <= '0;
      wr_valid <= 1'b0;
      wr_slot  <= 5'd0;
      wr_data  <= 32'd0;
      busy     <= 1'b0;
    end else begin
      // New write wins over the drain of the old one in the same cycle.
      if (chk_good) begin
        wr_valid <= 1'b1;
        wr_slot  <= slot_q;
        wr_data  <= coord_q;
      end else if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end

      if (accept) begin
        idle_cnt <= '0;
        case (state)
          HUNT: if (in_data == SYNC) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
          ADDR: if (addr_bad) begin
            state <= HUNT;
            busy  <= 1'b0;
          end else begin
            slot_q <= in_data[SLOT_W-1:0];
            chk_q  <= in_data;
            state  <= X;
          end
          X: begin
            coord_q.x <= in_data;
            chk_q     <= chk_q ^ in_data;
            state     <= Y;
          end
          Y: begin
            coord_q.y <= in_data;
            chk_q     <= chk_q ^ in_data;
            state     <= Z;
          end
          Z: begin
            coord_q.z <= in_data;
            chk_q     <= chk_q ^ in_data;
            state     <= T;
          end
          T: begin
            coord_q.t <= in_data;
            chk_q     <= chk_q ^ in_data;
            state     <= CHK;
          end
          CHK: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end else if ((state != HUNT) && in_ready && (TIMEOUT != 0)) begin
        if (timeout_hit) begin
          state    <= HUNT;
          busy     <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end

  telem_sat_cnt u_ok_cnt (
    .clk (clk),
    .rst (rst),
    .inc (chk_good),
    .cnt (ok_cnt)
  );

  telem_sat_cnt u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (addr_bad || chk_bad || timeout_hit),
    .cnt (err_cnt)
  );

endmodule

// File: doc/telem_frame_rx.md
# telem_frame_rx

Byte-stream telemetry frame receiver. It sits directly upstream of the 32-slot coordinate store. It hunts for a sync byte, then parses slot address, X/Y/Z/T coordinate bytes and an XOR checksum. For each valid frame it presents one write (slot index plus 32-bit packed coordinates) to the store through a valid/ready handshake, and keeps saturating good-frame and bad-frame counters.

## Interface

Parameters:
- TIMEOUT, default 255: idle cycles allowed between bytes inside a frame. 0 disables the timeout.
- SYNC, default 8'hA5: frame start byte.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  8  received byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready at posedge
- wr_valid  out  1  write pending to coordinate store
- wr_ready  in  1  store accepts write when wr_valid && wr_ready at posedge
- wr_slot  out  5  target slot, 0..31
- wr_data  out  32  {X,Y,Z,T}, X in [31:24]
- ok_cnt  out  16  good frames, saturating
- err_cnt  out  16  bad/aborted frames, saturating
- busy  out  1  state != HUNT

## Operation

- States and transitions (advance on each accepted byte):
  - HUNT: SYNC byte → ADDR. Any other byte is discarded.
  - ADDR: bits[7:5] != 0 → err_cnt++, go to HUNT. Otherwise latch slot = bits[4:0], chk = byte, go to X.
  - X → Y → Z → T: latch the byte, chk ^= byte.
  - CHK: byte == chk → load the output register, ok_cnt++, go to HUNT. Mismatch → err_cnt++, go to HUNT, output untouched.
- A SYNC value outside HUNT is ordinary data. There is no resync mid-frame.
- Output register: wr_valid set on a good CHK and cleared on wr_valid && wr_ready. wr_slot and wr_data stay stable while wr_valid=1.
- in_ready = 0 only when state == CHK && wr_valid && !wr_ready. It is 1 otherwise, including in HUNT.
- Simultaneous events:
  - Good CHK accepted in the same cycle the old write handshakes: the new write loads and wr_valid stays 1.
  - A bad CHK in that same cycle lets the old write complete normally.
- Timeout:
  - An idle counter runs in any state except HUNT. It clears on each accepted byte and freezes while in_ready = 0.
  - When it reaches TIMEOUT: go to HUNT, err_cnt++.
- Counters saturate at 16'hFFFF.
- Both counters increment in the same cycle only from the timeout path and a byte error, which are mutually exclusive; no double count.
- Reset values: state HUNT, wr_valid 0, wr_slot 0, wr_data 0, ok_cnt 0, err_cnt 0, busy 0, idle counter 0. Reset mid-frame discards the partial frame and any pending write.

## Timing

- CHK byte accepted at edge N → wr_valid = 1 and the counter update are visible after edge N. Latency is 1 cycle.
- Throughput: one byte per cycle. Minimum 7 cycles per frame with no backpressure.
- Timeout fires at the edge where the idle count equals TIMEOUT, i.e. TIMEOUT idle cycles after the last accepted byte.
- All outputs are registered except in_ready, which is combinational from state, wr_valid and wr_ready.

## Structure

- Package telem_pkg holds:
  - SYNC default, SLOT_W = 5, COORD_W = 8
  - state enum {HUNT, ADDR, X, Y, Z, T, CHK}
  - a packed coordinate struct {x, y, z, t}
- One sub-module, telem_sat_cnt: 16-bit saturating counter with rst and inc. It is instantiated twice (ok, err).

## Test plan

- Frame A5 03 10 20 30 40 43 with wr_ready = 1 → one wr_valid pulse with wr_slot = 3, wr_data = 32'h10203040; ok_cnt = 1, err_cnt = 0.
- Same frame with CHK = 44 → no wr_valid; err_cnt = 1. A following good frame is accepted (ok_cnt = 1).
- Address byte 23 → err_cnt = 1 and back to HUNT. Bytes 10 20 30 40 43 that follow are ignored until the next A5.
- wr_ready = 0, two back-to-back good frames (slots 3 and 7):
  - in_ready drops at the second CHK; wr_slot stays 3.
  - Raising wr_ready → slot 3 handshakes, slot 7 loads the same cycle, then handshakes.
- TIMEOUT = 8: send A5 03, then idle 8 cycles → err_cnt = 1, busy = 0. Stalled CHK under backpressure for 20 cycles → no timeout.
- rst asserted after A5 03 10 → all outputs zero, state HUNT. Trailing 20 30 40 43 produce no write.
